// File: rtl/register_store_unit_if.sv
// register_store_unit_if: data-memory word write port (request, address, data, ready)
interface register_store_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              mem_writeEnable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_ready;

    modport master (
        output mem_writeEnable,
        output mem_address,
        output mem_writeData,
        input  mem_ready
    );

    modport slave (
        input  mem_writeEnable,
        input  mem_address,
        input  mem_writeData,
        output mem_ready
    );
endinterface

// File: rtl/register_store_unit.sv
// register_store_unit: stores the 32-bit columns of one 128-bit register as sequential memory word writes
module register_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            srcReg,
    input  logic [ADDR_W-1:0]     baseAddr,
    input  logic [3:0]            laneMask,
    output logic [3:0]            rf_readAddress,
    input  logic [4*DATA_W-1:0]   rf_readData,
    register_store_unit_if.master mem,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state, stateNext;
    logic [ADDR_W-1:0]   baseLatch;
    logic [3:0]          maskLatch;
    logic [1:0]          lane;
    logic [4*DATA_W-1:0] snapshot;
    logic [2:0]          scanFrom;
    logic                hasNext;
    logic [1:0]          nextLane;

    // Find the lowest enabled column at or above scanFrom; READ scans from 0, WRITE from lane+1
    always_comb begin
        scanFrom = (state == READ) ? 3'd0 : {1'b0, lane} + 3'd1;
        hasNext  = 1'b0;
        nextLane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (maskLatch[i] && 3'(i) >= scanFrom) begin
                hasNext  = 1'b1;
                nextLane = 2'(i);
            end
        end
    end

    // Next-state decode; WRITE only advances when memory accepts the word
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = start ? READ : IDLE;
            READ:    stateNext = hasNext ? WRITE : DONE;
            WRITE:   stateNext = (mem.mem_ready && !hasNext) ? DONE : WRITE;
            default: stateNext = IDLE;
        endcase
    end

    // State register; reset aborts any store in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Request latch, register snapshot and lane cursor
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_readAddress <= '0;
            baseLatch      <= '0;
            maskLatch      <= '0;
            lane           <= '0;
            snapshot       <= '0;
        end else begin
            if (state == IDLE && start) begin
                rf_readAddress <= srcReg;
                baseLatch      <= baseAddr;
                maskLatch      <= laneMask;
            end
            if (state == READ) begin
                snapshot <= rf_readData;
                lane     <= nextLane;
            end
            if (state == WRITE && mem.mem_ready && hasNext) lane <= nextLane;
        end
    end

    // Address always tracks base+column so masked-off columns still consume their slot
    assign mem.mem_writeEnable = (state == WRITE);
    assign mem.mem_address     = baseLatch + ADDR_W'(lane);
    assign mem.mem_writeData   = snapshot[DATA_W*lane +: DATA_W];
    assign busy                = (state != IDLE);
    assign done                = (state == DONE);
endmodule
